// File: rtl/detect_seq_pkg.sv
// Shared definitions for the detect sequencer slice.
//   state_e  : controller states (IDLE, ARMED, WINDOW, REPORT, HOLDOFF)
//   ts_none  : all-ones "no hit" timestamp pattern for a given width
package detect_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_WINDOW,
    ST_REPORT,
    ST_HOLDOFF
  } state_e;

  // Low `width` bits set; callers slice to their timestamp width.
  function automatic logic [63:0] ts_none(input int unsigned width);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < width) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/detect_ts_slot.sv
// One detector channel's capture slot: hit flag plus timestamp register.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear         return slot to "no hit" (ts all-ones)
//   capture_en    channel pulse seen while capturing; ignored once hit is set
//   timer         current window timer value to store on capture
//   hit, ts       captured flag and timestamp
module detect_ts_slot
  import detect_seq_pkg::*;
#(
  parameter int unsigned TS_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                capture_en,
  input  logic [TS_WIDTH-1:0] timer,
  output logic                hit,
  output logic [TS_WIDTH-1:0] ts
);

  localparam logic [63:0]         NONE_64 = ts_none(TS_WIDTH);
  localparam logic [TS_WIDTH-1:0] TS_NONE = NONE_64[TS_WIDTH-1:0];

  logic                hit_q, hit_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;

  always_comb begin
    hit_d = hit_q;
    ts_d  = ts_q;
    if (clear) begin
      hit_d = 1'b0;
      ts_d  = TS_NONE;
    end else if (capture_en && !hit_q) begin
      // Only the first pulse of a frame is kept; repeats fall through.
      hit_d = 1'b1;
      ts_d  = timer;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q <= 1'b0;
      ts_q  <= TS_NONE;
    end else begin
      hit_q <= hit_d;
      ts_q  <= ts_d;
    end
  end

  assign hit = hit_q;
  assign ts  = ts_q;

endmodule

// File: rtl/detect_sequencer.sv
// Sequencer above the per-microphone threshold detectors. Arms the channels,
// timestamps each channel's first pulse relative to the earliest one in a
// capture window, offers the frame on valid/ready, then holds the detectors
// in reset for a dead time.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   enable        run capture cycles while high
//   detect        one-cycle detect pulses, one bit per channel
//   ch_rst        active-high reset to the detector channels
//   res_valid     result frame valid; res_ready accepts it
//   hit_mask      channels captured in the frame
//   ts_data       channel i timestamp at [i*TS_WIDTH +: TS_WIDTH], all-ones = none
//   busy          high in every state except IDLE
//   missed        saturating count of pulses ignored outside ARMED/WINDOW
module detect_sequencer
  import detect_seq_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned TS_WIDTH   = 16,
  parameter int unsigned WINDOW     = 20000,
  parameter int unsigned HOLDOFF    = 50000,
  parameter int unsigned MISS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [N_CH-1:0]          detect,
  output logic                     ch_rst,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [N_CH-1:0]          hit_mask,
  output logic [N_CH*TS_WIDTH-1:0] ts_data,
  output logic                     busy,
  output logic [MISS_WIDTH-1:0]    missed
);

  localparam logic [31:0]           WIN_LAST  = 32'(WINDOW - 1);
  localparam logic [31:0]           HOLD_LAST = 32'(HOLDOFF - 1);
  localparam logic [MISS_WIDTH-1:0] MISS_MAX  = '1;

  state_e                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;      // window timer / holdoff counter
  logic [MISS_WIDTH-1:0] missed_q, missed_d;
  logic [N_CH-1:0]       capture_en;
  logic [N_CH-1:0]       hit_w;
  logic                  clear_slots;

  // Adds the number of set bits, clamping at the counter's maximum.
  function automatic logic [MISS_WIDTH-1:0] sat_add(
    input logic [MISS_WIDTH-1:0] acc,
    input logic [N_CH-1:0]       bits
  );
    logic [MISS_WIDTH:0] sum;
    sum = {1'b0, acc};
    for (int i = 0; i < N_CH; i++) begin
      sum = sum + {{MISS_WIDTH{1'b0}}, bits[i]};
      if (sum > {1'b0, MISS_MAX}) sum = {1'b0, MISS_MAX};
    end
    return sum[MISS_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    missed_d    = missed_q;
    capture_en  = '0;
    clear_slots = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        cnt_d = '0;
        if (detect != '0) begin
          // First detection defines t=0 for every channel firing now.
          capture_en = detect;
          cnt_d      = 32'd1;
          // A one-cycle window is already complete after this capture.
          state_d    = (WINDOW == 1) ? ST_REPORT : ST_WINDOW;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_WINDOW: begin
        capture_en = detect;
        cnt_d      = cnt_q + 32'd1;
        if (((hit_w | detect) == '1) || (cnt_q == WIN_LAST)) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (res_ready) begin
          state_d = ST_HOLDOFF;
          cnt_d   = '0;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          clear_slots = 1'b1;
          cnt_d       = '0;
          state_d     = enable ? ST_ARMED : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q inside {ST_IDLE, ST_REPORT, ST_HOLDOFF}) && (detect != '0)) begin
      missed_d = sat_add(missed_q, detect);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_slot
    detect_ts_slot #(
      .TS_WIDTH(TS_WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear_slots),
      .capture_en(capture_en[i]),
      .timer     (cnt_q[TS_WIDTH-1:0]),
      .hit       (hit_w[i]),
      .ts        (ts_data[i*TS_WIDTH +: TS_WIDTH])
    );
  end

  assign hit_mask  = hit_w;
  assign ch_rst    = !((state_q == ST_ARMED) || (state_q == ST_WINDOW));
  assign res_valid = (state_q == ST_REPORT);
  assign busy      = (state_q != ST_IDLE);
  assign missed    = missed_q;

endmodule

// File: tb/tb_detect_sequencer.sv
// Bench for detect_sequencer: directed scenarios followed by randomized
// traffic, checked against a cycle-numbered behavioural model. Frames are
// pushed to a queue when the model completes them and popped by a monitor.
module tb_detect_sequencer;

  localparam int N_CH = 4;
  localparam int TS_W = 16;
  localparam int WIN  = 100;
  localparam int HOLD = 20;
  localparam int MW   = 6;
  localparam int MISS_SAT = (1 << MW) - 1;

  localparam int P_IDLE = 0, P_ARMED = 1, P_WINDOW = 2, P_REPORT = 3, P_HOLD = 4;

  typedef struct packed {
    logic [N_CH-1:0]      mask;
    logic [N_CH*TS_W-1:0] ts;
  } frame_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 enable = 1'b0;
  logic [N_CH-1:0]      detect = '0;
  logic                 res_ready = 1'b0;
  logic                 ch_rst;
  logic                 res_valid;
  logic [N_CH-1:0]      hit_mask;
  logic [N_CH*TS_W-1:0] ts_data;
  logic                 busy;
  logic [MW-1:0]        missed;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: absolute edge numbers rather than counters.
  int     cyc = 0;
  int     mphase;
  int     first_cyc;
  int     hold_end;
  int     hit_at [N_CH];
  int     mmissed;
  frame_t exp_q [$];

  detect_sequencer #(
    .N_CH(N_CH), .TS_WIDTH(TS_W), .WINDOW(WIN), .HOLDOFF(HOLD), .MISS_WIDTH(MW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .detect(detect), .ch_rst(ch_rst),
    .res_valid(res_valid), .res_ready(res_ready), .hit_mask(hit_mask),
    .ts_data(ts_data), .busy(busy), .missed(missed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic frame_t model_frame();
    frame_t f;
    f.mask = '0;
    f.ts   = '1;
    for (int i = 0; i < N_CH; i++) begin
      if (hit_at[i] >= 0) begin
        f.mask[i]          = 1'b1;
        f.ts[i*TS_W +: TS_W] = 16'(hit_at[i] - first_cyc);
      end
    end
    return f;
  endfunction

  function automatic void model_reset();
    mphase    = P_IDLE;
    mmissed   = 0;
    first_cyc = 0;
    hold_end  = 0;
    for (int i = 0; i < N_CH; i++) hit_at[i] = -1;
    exp_q.delete();
  endfunction

  function automatic void add_missed(input logic [N_CH-1:0] det);
    mmissed = mmissed + $countones(det);
    if (mmissed > MISS_SAT) mmissed = MISS_SAT;
  endfunction

  function automatic bit all_hit();
    bit a = 1'b1;
    for (int i = 0; i < N_CH; i++) if (hit_at[i] < 0) a = 1'b0;
    return a;
  endfunction

  function automatic void finish_frame();
    mphase = P_REPORT;
    exp_q.push_back(model_frame());
  endfunction

  function automatic void model_step(input logic en, input logic [N_CH-1:0] det, input logic rdy);
    case (mphase)
      P_IDLE: begin
        add_missed(det);
        if (en) mphase = P_ARMED;
      end
      P_ARMED: begin
        if (det != '0) begin
          first_cyc = cyc;
          for (int i = 0; i < N_CH; i++) if (det[i]) hit_at[i] = cyc;
          if (WIN == 1) finish_frame();
          else mphase = P_WINDOW;
        end else if (!en) begin
          mphase = P_IDLE;
        end
      end
      P_WINDOW: begin
        for (int i = 0; i < N_CH; i++) if (det[i] && hit_at[i] < 0) hit_at[i] = cyc;
        if (all_hit() || (cyc - first_cyc == WIN - 1)) finish_frame();
      end
      P_REPORT: begin
        add_missed(det);
        if (rdy) begin
          mphase   = P_HOLD;
          hold_end = cyc + HOLD;
        end
      end
      default: begin
        add_missed(det);
        if (cyc == hold_end) begin
          for (int i = 0; i < N_CH; i++) hit_at[i] = -1;
          mphase = en ? P_ARMED : P_IDLE;
        end
      end
    endcase
  endfunction

  // Model advances on every rising edge; reset also acts asynchronously.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) model_reset();
      else model_step(enable, detect, res_ready);
    end
  end

  initial begin
    forever begin
      @(negedge rst);
      model_reset();
    end
  end

  // Monitor: status every cycle, frames from the scoreboard queue.
  initial begin
    logic [127:0] exp_s;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_s = {51'd0,
                 1'(!(mphase == P_ARMED || mphase == P_WINDOW)),
                 1'(mphase != P_IDLE),
                 1'(mphase == P_REPORT),
                 6'(mmissed),
                 model_frame()};
        check("status", {51'd0, ch_rst, busy, res_valid, missed, hit_mask, ts_data}, exp_s);
        if (res_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_unexpected: got mask %0h ts %0h expected no frame", hit_mask, ts_data);
          end else begin
            check("frame", {hit_mask, ts_data}, exp_q[0]);
            if (res_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N_CH-1:0] v);
    detect = v;
    tick();
    detect = '0;
  endtask

  task automatic pulse_at(input logic [N_CH-1:0] v, input int e);
    while (cyc < e - 1) tick();
    pulse(v);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    check(name, res_valid, 1);
  endtask

  task automatic wait_armed(input string name, input int budget);
    int n = 0;
    while (ch_rst && n < budget) begin
      tick();
      n++;
    end
    check(name, ch_rst, 0);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    check(name, {ch_rst, res_valid, hit_mask, ts_data, busy, missed},
          {1'b1, 1'b0, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'd0});
  endtask

  initial begin
    int t0;
    int a;
    int n;
    int dens;

    repeat (3) tick();
    check_reset_values("reset_state");
    rst = 1'b1;
    tick();
    tick();
    check("idle_busy", {busy, ch_rst}, {1'b0, 1'b1});

    enable = 1'b1;
    tick();
    check("arm_latency", {busy, ch_rst}, {1'b1, 1'b0});

    // Single channel, window runs to timeout.
    pulse_at(4'b0001, cyc + 10);
    t0 = cyc;
    wait_valid("single_valid", WIN + 20);
    check("single_latency", cyc - t0, WIN - 1);
    check("single_mask", hit_mask, 4'b0001);
    check("single_ts", ts_data, 64'hFFFF_FFFF_FFFF_0000);
    accept();
    wait_armed("single_rearm", HOLD + 10);

    // Staggered hits, early exit on the fourth channel.
    t0 = cyc + 3;
    pulse_at(4'b0100, t0);
    pulse_at(4'b0001, t0 + 5);
    pulse_at(4'b1000, t0 + 17);
    check("stagger_no_early", res_valid, 0);
    pulse_at(4'b0010, t0 + 40);
    check("stagger_exit", res_valid, 1);
    check("stagger_mask", hit_mask, 4'b1111);
    check("stagger_ts", ts_data, {16'd17, 16'd0, 16'd40, 16'd5});
    accept();
    wait_armed("stagger_rearm", HOLD + 10);

    // Simultaneous first hit, then a repeat on an already-captured channel.
    t0 = cyc + 2;
    pulse_at(4'b1010, t0);
    pulse_at(4'b0010, t0 + 3);
    wait_valid("repeat_valid", WIN + 20);
    check("repeat_mask", hit_mask, 4'b1010);
    check("repeat_ts", ts_data, 64'h0000_FFFF_0000_FFFF);
    check("repeat_missed", missed, 0);

    // Backpressure with pulses: frame frozen, pulses counted.
    for (int i = 0; i < 50; i++) begin
      detect = (i % 5 == 0) ? 4'b0011 : 4'b0000;
      tick();
      check("bp_frozen", {ch_rst, res_valid, hit_mask, ts_data},
            {1'b1, 1'b1, 4'b1010, 64'h0000_FFFF_0000_FFFF});
    end
    detect = '0;
    check("bp_missed", missed, 20);
    accept();
    a = cyc;
    n = 0;
    while (ch_rst && n < HOLD + 10) begin
      tick();
      n++;
    end
    check("holdoff_len", cyc - a, HOLD);
    check("holdoff_clear", {hit_mask, ts_data}, {4'b0000, 64'hFFFF_FFFF_FFFF_FFFF});

    // Boundary: last window cycle captured, the next one is missed.
    t0 = cyc + 2;
    pulse_at(4'b0001, t0);
    pulse_at(4'b0010, t0 + WIN - 1);
    check("boundary_exit", res_valid, 1);
    pulse_at(4'b0100, t0 + WIN);
    check("boundary_ts", ts_data, 64'hFFFF_FFFF_0063_0000);
    check("boundary_mask", hit_mask, 4'b0011);
    check("boundary_missed", missed, 21);
    accept();
    wait_armed("boundary_rearm", HOLD + 10);

    // Asynchronous reset mid-window.
    t0 = cyc + 2;
    pulse_at(4'b0001, t0);
    repeat (5) tick();
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("reset_mid_window");
    enable = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("post_reset_idle", {busy, ch_rst, res_valid}, {1'b0, 1'b1, 1'b0});

    // Asynchronous reset mid-report.
    enable = 1'b1;
    tick();
    pulse(4'b1111);
    wait_valid("report_valid", 10);
    check("report_all_mask", hit_mask, 4'b1111);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("reset_mid_report");
    enable = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("post_reset_idle2", {busy, ch_rst}, {1'b0, 1'b1});

    // Randomized traffic with varying pulse density.
    enable = 1'b1;
    for (int seg = 0; seg < 8; seg++) begin
      case ($urandom_range(0, 2))
        0:       dens = 4;
        1:       dens = 40;
        default: dens = 300;
      endcase
      for (int c = 0; c < 600; c++) begin
        for (int b = 0; b < N_CH; b++) detect[b] = ($urandom_range(0, dens - 1) == 0);
        res_ready = ($urandom_range(0, 2) == 0);
        if (enable && $urandom_range(0, 249) == 0) enable = 1'b0;
        else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
        tick();
      end
    end
    detect    = '0;
    res_ready = 1'b1;
    repeat (WIN + HOLD + 10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
